// File: rtl/ysyx_23060303_regfile_sb.sv
// ysyx_23060303_regfile_sb
// Integer register file for the pipelined core with a per-register busy
// scoreboard used by decode to detect RAW/WAW hazards.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   wen, waddr, wdata     writeback write port
//   raddr / rdata         NR_READ packed read ports (port i at [i*W +: W])
//   rbusy                 per read port: addressed register has an outstanding writer
//   issue_en, issue_rd    request to mark issue_rd busy
//   issue_ready           issue of issue_rd can be accepted this cycle
//   flush                 clears every busy bit
//   busy_cnt              number of registers currently busy
//
// Register 0 is hard-wired: reads 0, ignores writes, is never busy.

module ysyx_23060303_regfile_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_READ    = 2,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wen,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [NR_READ*ADDR_WIDTH-1:0]    raddr,
    output logic [NR_READ*DATA_WIDTH-1:0]    rdata,
    output logic [NR_READ-1:0]               rbusy,
    input  logic                             issue_en,
    input  logic [ADDR_WIDTH-1:0]            issue_rd,
    output logic                             issue_ready,
    input  logic                             flush,
    output logic [ADDR_WIDTH:0]              busy_cnt
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int CNT_WIDTH = ADDR_WIDTH + 1;
    localparam bit BYP_EN    = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]      busy_reg;
    logic [DEPTH-1:0]      busy_next;
    logic [CNT_WIDTH-1:0]  busy_cnt_reg;
    logic [CNT_WIDTH-1:0]  busy_cnt_next;

    logic wr_active;
    logic issue_take;
    logic wb_clears_busy;

    // A write to x0 has no architectural effect anywhere.
    assign wr_active = wen & (waddr != '0);

    // A writer landing this cycle frees its register, so a WAW issue to it
    // does not have to stall.
    assign issue_ready = (issue_rd == '0) | ~busy_reg[issue_rd]
                       | (wen & (waddr == issue_rd));

    // x0 issues are "accepted" from decode's point of view but mark nothing.
    assign issue_take = issue_en & issue_ready & ~flush & (issue_rd != '0);

    assign wb_clears_busy = wr_active & busy_reg[waddr];

    // ------------------------------------------------------------------
    // Register array. Asynchronous clear forces a flop array; x0 is
    // cleared on reset and never written afterwards.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_active) begin
            regs_reg[waddr] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Busy scoreboard: flush > accepted issue > writeback clear > hold.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                logic set_hit;
                logic clr_hit;
                assign set_hit = issue_take & (issue_rd == ADDR_WIDTH'(gi));
                assign clr_hit = wr_active & (waddr == ADDR_WIDTH'(gi));
                assign busy_next[gi] = ~flush & (set_hit | (busy_reg[gi] & ~clr_hit));
            end
        end
    endgenerate

    // The count tracks the bits incrementally. An accepted issue can only
    // target a non-busy register or one being cleared in the same cycle, so
    // a simultaneous issue+clear of one register nets to zero.
    assign busy_cnt_next = flush ? '0
                         : busy_cnt_reg + CNT_WIDTH'(issue_take) - CNT_WIDTH'(wb_clears_busy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg     <= '0;
            busy_cnt_reg <= '0;
        end else begin
            busy_reg     <= busy_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign busy_cnt = busy_cnt_reg;

    // ------------------------------------------------------------------
    // Read ports. The rst_n gating keeps a bypassed write from leaking
    // onto rdata while the file is held in reset.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NR_READ; gi++) begin : g_read
            logic [ADDR_WIDTH-1:0] ra;
            logic                  byp_hit;

            assign ra      = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign byp_hit = BYP_EN & wen & (waddr == ra);

            assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] =
                (!rst_n || ra == '0) ? '0 :
                byp_hit              ? wdata :
                                       regs_reg[ra];

            assign rbusy[gi] = rst_n & busy_reg[ra] & ~byp_hit;
        end
    endgenerate

endmodule
